bitserial_pe_ctrl: RTL and testbench
====================================

Name: bitserial_pe_ctrl

Overview:
Sequencer that runs multi-bit, optionally signed dot products on the 1-bit PE by streaming bit-planes.
- Accepts one packed operand pair per transaction.
- Issues one (activation-bit, weight-bit) plane pair per cycle to the PE and drives the PE sign inputs on MSB planes.
- Shift-accumulates the PE's registered PSUM into a full-precision result and returns it with a valid/ready handshake.
- Sits between the tile's operand buffers and one PE instance.

Parameters:
LANES, 16, elements per dot product; equals PE activation/weight vector width
MAX_BITS, 8, maximum operand precision in bits
PSUM_W, 6, width of signed PE PSUM output
ACC_W, 22, result accumulator width (PSUM_W + 2*MAX_BITS)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
i_Valid  in  1  operand transaction valid
o_Ready  out  1  controller can accept a transaction (high only in IDLE)
i_Act  in  LANES*MAX_BITS  activations, lane l bits [l*MAX_BITS +: MAX_BITS], LSB-aligned
i_Weight  in  LANES*MAX_BITS  weights, same packing
i_ActBits  in  4  activation precision, 1..MAX_BITS
i_WBits  in  4  weight precision, 1..MAX_BITS
i_ActSigned  in  1  activations are two's complement
i_WSigned  in  1  weights are two's complement
o_PE_Act  out  LANES  activation bit-plane to PE
o_PE_Weight  out  LANES  weight bit-plane to PE
o_SignI  out  1  PE i_SignI: current activation plane is a signed MSB
o_SignW  out  1  PE i_SignW: current weight plane is a signed MSB
i_PE_PSUM  in  PSUM_W  signed PE output, registered one cycle after its inputs
o_Result  out  ACC_W  signed dot-product result
o_Valid  out  1  result valid
i_ResultReady  in  1  consumer accepts result

Behaviour:
Reset values:
- State = IDLE; o_Ready = 1; o_Valid = 0; o_Result = 0; accumulator = 0.
- o_PE_Act, o_PE_Weight, o_SignI, o_SignW = 0.

Bits clamping: ActBits/WBits of 0 are treated as 1; values > MAX_BITS are treated as MAX_BITS.

States:
- IDLE: on i_Valid & o_Ready, register operands, clamped bit counts and sign flags; clear accumulator; -> RUN. Let N = AB*WB.
- RUN: one plane pair per cycle for N cycles. Weight bit j is the outer loop, activation bit i the inner loop, both LSB first.
  - o_PE_Act[l] = act_l[i]; o_PE_Weight[l] = weight_l[j].
  - o_SignI = ActSigned & (i == AB-1); o_SignW = WSigned & (j == WBits-1).
  - Shift amount i+j is delayed one cycle to align with i_PE_PSUM.
  - From the second RUN cycle on: acc += sign_extend(i_PE_PSUM) << shift_d.
  - After the last pair -> DRAIN.
- DRAIN: PE plane outputs = 0, signs = 0; accumulate the final PSUM; -> DONE.
- DONE: o_Valid = 1 and o_Result = acc, held stable while i_ResultReady = 0. On i_ResultReady -> IDLE, o_Valid = 0 next cycle. o_Result keeps its last value.

Outside RUN: PE plane outputs and signs are driven 0, so the PE sees zero.

Timing:
- Latency: accept edge to o_Valid = N+2 cycles.
- Throughput: one transaction per N+3 cycles minimum, since accept is only possible in IDLE.

Stability:
- Operand inputs and i_Valid changes after accept are ignored.
- o_Ready = 0 in RUN, DRAIN and DONE.

Arithmetic:
- All accumulation is signed.
- Two's-complement MSB weighting comes from the PE sign handling; the controller only gates the signs.
- ACC_W is sized so that no overflow can occur at max precision.

Reset mid-operation: RST in any state returns to IDLE with reset values next cycle. A partial result is discarded and o_Valid never pulses.

Test Plan:
- 1b x 1b unsigned, all act=1, all weight=1 -> PE planes all-ones for 1 cycle, o_Valid at cycle 3 after accept, o_Result = 16.
- AB=2 signed, act=-1 (2'b11) all lanes; WB=2 unsigned, weight=3 -> o_SignI high on i=1 planes only, o_SignW never high, 4 RUN cycles, o_Result = -48, latency 6.
- 8b x 8b both signed, act=-128, weight=-128 all lanes -> o_SignI & o_SignW together only on the last plane pair, o_Result = 262144, latency 66; repeat with weight=127 -> o_Result = -260096.
- Backpressure: i_ResultReady low 5 cycles in DONE -> o_Valid and o_Result stable, o_Ready = 0, a new i_Valid is not accepted; release -> IDLE, and a back-to-back transaction is accepted on the following cycle.
- RST asserted on 3rd RUN cycle of a 4x4 job -> next cycle IDLE, o_Ready = 1, PE outputs 0, o_Valid stays 0. A subsequent 1x1 job (sum 16) returns exactly 16, with no residue from the aborted job.
- i_ActBits = 0 and i_WBits = 12 -> treated as 1 and 8; 8 RUN cycles and a result matching a 1x8 reference model.

Source files
------------

// File: rtl/bitserial_pe_ctrl.sv
// Bit-serial sequencer: streams activation/weight bit-planes into a 1-bit PE and
// shift-accumulates the returned partial sums into a signed dot-product result.
module bitserial_pe_ctrl #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned MAX_BITS = 8,
  parameter int unsigned PSUM_W   = 6,
  parameter int unsigned ACC_W    = 22
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  input  logic [LANES*MAX_BITS-1:0] i_Act,
  input  logic [LANES*MAX_BITS-1:0] i_Weight,
  input  logic [3:0]                i_ActBits,
  input  logic [3:0]                i_WBits,
  input  logic                      i_ActSigned,
  input  logic                      i_WSigned,
  output logic [LANES-1:0]          o_PE_Act,
  output logic [LANES-1:0]          o_PE_Weight,
  output logic                      o_SignI,
  output logic                      o_SignW,
  input  logic [PSUM_W-1:0]         i_PE_PSUM,
  output logic [ACC_W-1:0]          o_Result,
  output logic                      o_Valid,
  input  logic                      i_ResultReady
);

  localparam int unsigned CNT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int unsigned SH_W  = CNT_W + 1;
  localparam logic [3:0]  MAX_BITS_4 = 4'(MAX_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LANES*MAX_BITS-1:0] r_act;
  logic [LANES*MAX_BITS-1:0] r_wgt;
  logic [CNT_W-1:0]          r_alast;
  logic [CNT_W-1:0]          r_wlast;
  logic                      r_asigned;
  logic                      r_wsigned;
  logic [CNT_W-1:0]          r_i;
  logic [CNT_W-1:0]          r_j;
  logic [SH_W-1:0]           r_shift_d;
  logic                      r_pe_vld;
  logic [ACC_W-1:0]          r_acc;
  logic [ACC_W-1:0]          r_result;

  logic [3:0]       w_ab;
  logic [3:0]       w_wb;
  logic             w_last_i;
  logic             w_last_pair;
  logic [ACC_W-1:0] w_psum_ext;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_acc_next;
  logic [LANES-1:0] w_act_plane;
  logic [LANES-1:0] w_wgt_plane;

  // Precision clamp to 1..MAX_BITS
  always_comb begin
    w_ab = i_ActBits;
    w_wb = i_WBits;
    if (i_ActBits == 4'd0)            w_ab = 4'd1;
    else if (i_ActBits > MAX_BITS_4)  w_ab = MAX_BITS_4;
    if (i_WBits == 4'd0)              w_wb = 4'd1;
    else if (i_WBits > MAX_BITS_4)    w_wb = MAX_BITS_4;
  end

  assign w_last_i    = (r_i == r_alast);
  assign w_last_pair = w_last_i && (r_j == r_wlast);

  // PSUM lags its planes by one cycle, so the shift it uses is the delayed one
  assign w_psum_ext = {{(ACC_W-PSUM_W){i_PE_PSUM[PSUM_W-1]}}, i_PE_PSUM};
  assign w_term     = w_psum_ext << r_shift_d;
  assign w_acc_next = r_acc + (r_pe_vld ? w_term : '0);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [MAX_BITS-1:0] w_a_lane;
    logic [MAX_BITS-1:0] w_w_lane;
    assign w_a_lane       = r_act[g*MAX_BITS +: MAX_BITS];
    assign w_w_lane       = r_wgt[g*MAX_BITS +: MAX_BITS];
    assign w_act_plane[g] = w_a_lane[r_i];
    assign w_wgt_plane[g] = w_w_lane[r_j];
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_Valid)       w_state_next = S_RUN;
      S_RUN:   if (w_last_pair)   w_state_next = S_DRAIN;
      S_DRAIN:                    w_state_next = S_DONE;
      S_DONE:  if (i_ResultReady) w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  // Outputs: PE sees zero planes and signs outside RUN
  always_comb begin
    o_Ready     = 1'b0;
    o_Valid     = 1'b0;
    o_PE_Act    = '0;
    o_PE_Weight = '0;
    o_SignI     = 1'b0;
    o_SignW     = 1'b0;
    case (r_state)
      S_IDLE: o_Ready = 1'b1;
      S_RUN: begin
        o_PE_Act    = w_act_plane;
        o_PE_Weight = w_wgt_plane;
        o_SignI     = r_asigned && w_last_i;
        o_SignW     = r_wsigned && (r_j == r_wlast);
      end
      S_DONE:  o_Valid = 1'b1;
      default: ;
    endcase
  end

  assign o_Result = r_result;

  // Operand capture, plane counters and shift-accumulate
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_act     <= '0;
      r_wgt     <= '0;
      r_alast   <= '0;
      r_wlast   <= '0;
      r_asigned <= 1'b0;
      r_wsigned <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_shift_d <= '0;
      r_pe_vld  <= 1'b0;
      r_acc     <= '0;
      r_result  <= '0;
    end else begin
      r_pe_vld  <= (r_state == S_RUN);
      r_shift_d <= SH_W'(r_i) + SH_W'(r_j);
      case (r_state)
        S_IDLE: begin
          if (i_Valid) begin
            r_act     <= i_Act;
            r_wgt     <= i_Weight;
            r_alast   <= CNT_W'(w_ab - 4'd1);
            r_wlast   <= CNT_W'(w_wb - 4'd1);
            r_asigned <= i_ActSigned;
            r_wsigned <= i_WSigned;
            r_i       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (w_last_i) begin
            r_i <= '0;
            r_j <= r_j + CNT_W'(1);
          end else begin
            r_i <= r_i + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          r_acc    <= w_acc_next;
          r_result <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_pe_ctrl.sv
// Randomized bench for bitserial_pe_ctrl with a behavioural 1-bit PE and an
// arithmetic dot-product reference.
module tb_bitserial_pe_ctrl;

  localparam int LANES  = 16;
  localparam int MB     = 8;
  localparam int PSUM_W = 6;
  localparam int ACC_W  = 22;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   i_Valid;
  logic                   o_Ready;
  logic [LANES*MB-1:0]    i_Act;
  logic [LANES*MB-1:0]    i_Weight;
  logic [3:0]             i_ActBits;
  logic [3:0]             i_WBits;
  logic                   i_ActSigned;
  logic                   i_WSigned;
  logic [LANES-1:0]       o_PE_Act;
  logic [LANES-1:0]       o_PE_Weight;
  logic                   o_SignI;
  logic                   o_SignW;
  logic [PSUM_W-1:0]      pe_psum;
  logic [PSUM_W-1:0]      pe_next;
  logic [ACC_W-1:0]       o_Result;
  logic                   o_Valid;
  logic                   i_ResultReady;

  int n_vec = 0;
  int n_err = 0;

  logic [MB-1:0] act [LANES];
  logic [MB-1:0] wgt [LANES];

  bitserial_pe_ctrl dut (
    .CLK(CLK), .RST(RST), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Act(i_Act), .i_Weight(i_Weight), .i_ActBits(i_ActBits), .i_WBits(i_WBits),
    .i_ActSigned(i_ActSigned), .i_WSigned(i_WSigned),
    .o_PE_Act(o_PE_Act), .o_PE_Weight(o_PE_Weight), .o_SignI(o_SignI), .o_SignW(o_SignW),
    .i_PE_PSUM(pe_psum), .o_Result(o_Result), .o_Valid(o_Valid),
    .i_ResultReady(i_ResultReady)
  );

  always #5 CLK = ~CLK;

  // 1-bit PE: popcount of AND, negated when exactly one operand plane is a signed MSB
  assign pe_next = (o_SignI ^ o_SignW) ? PSUM_W'(0 - $countones(o_PE_Act & o_PE_Weight))
                                       : PSUM_W'($countones(o_PE_Act & o_PE_Weight));
  always_ff @(posedge CLK) pe_psum <= pe_next;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampb(input int b);
    if (b == 0) return 1;
    if (b > MB) return MB;
    return b;
  endfunction

  function automatic longint opval(input logic [MB-1:0] raw, input int bits, input bit sgn);
    longint v;
    v = longint'(raw) & ((longint'(1) << bits) - 1);
    if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v;
  endfunction

  task automatic scramble();
    i_Valid   = 1'($urandom);
    i_Act     = {$urandom, $urandom, $urandom, $urandom};
    i_Weight  = {$urandom, $urandom, $urandom, $urandom};
    i_ActBits = 4'($urandom);
    i_WBits   = 4'($urandom);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again
  task automatic run_job(input int ab_raw, input int wb_raw, input bit as, input bit ws,
                         input int hold);
    int ab, wb, n, k, bad, pi, pj;
    longint exp;
    logic [LANES-1:0] ea, ew;
    logic esi, esw;
    logic [ACC_W-1:0] res0;
    ab = clampb(ab_raw);
    wb = clampb(wb_raw);
    n  = ab * wb;
    exp = 0;
    for (int l = 0; l < LANES; l++) begin
      exp += opval(act[l], ab, as) * opval(wgt[l], wb, ws);
      i_Act[l*MB +: MB]    = act[l];
      i_Weight[l*MB +: MB] = wgt[l];
    end
    i_ActBits   = 4'(ab_raw);
    i_WBits     = 4'(wb_raw);
    i_ActSigned = as;
    i_WSigned   = ws;
    i_Valid     = 1'b1;
    @(posedge CLK); #1;
    chk("accept_ready_low", longint'(o_Ready), 0);
    k = 0;
    bad = 0;
    while (o_Valid !== 1'b1 && k < 200) begin
      ea = '0; ew = '0; esi = 1'b0; esw = 1'b0;
      if (k < n) begin
        pi = k % ab;
        pj = k / ab;
        for (int l = 0; l < LANES; l++) begin
          ea[l] = act[l][pi];
          ew[l] = wgt[l][pj];
        end
        esi = as && (pi == ab - 1);
        esw = ws && (pj == wb - 1);
      end
      if (o_PE_Act !== ea || o_PE_Weight !== ew || o_SignI !== esi || o_SignW !== esw ||
          o_Ready !== 1'b0)
        bad++;
      scramble();
      k++;
      @(posedge CLK); #1;
    end
    i_Valid = 1'b0;
    chk("latency", k + 1, n + 2);
    chk("planes", bad, 0);
    chk("result", longint'($signed(o_Result)), exp);
    res0 = o_Result;
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      i_Valid = 1'b1;
      @(posedge CLK); #1;
      if (o_Valid !== 1'b1 || o_Result !== res0 || o_Ready !== 1'b0 || o_PE_Act !== '0)
        bad++;
    end
    if (hold > 0) chk("backpressure_hold", bad, 0);
    i_Valid       = 1'b0;
    i_ResultReady = 1'b1;
    @(posedge CLK); #1;
    i_ResultReady = 1'b0;
    chk("release_valid", longint'(o_Valid), 0);
    chk("release_ready", longint'(o_Ready), 1);
    chk("result_kept", longint'($signed(o_Result)), exp);
  endtask

  task automatic fill(input logic [MB-1:0] a, input logic [MB-1:0] w);
    for (int l = 0; l < LANES; l++) begin
      act[l] = a;
      wgt[l] = w;
    end
  endtask

  task automatic fill_rand();
    for (int l = 0; l < LANES; l++) begin
      act[l] = MB'($urandom);
      wgt[l] = MB'($urandom);
    end
  endtask

  initial begin
    int bad;
    RST = 1'b1;
    i_Valid = 1'b0; i_Act = '0; i_Weight = '0; i_ActBits = 4'd1; i_WBits = 4'd1;
    i_ActSigned = 1'b0; i_WSigned = 1'b0; i_ResultReady = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready", longint'(o_Ready), 1);
    chk("reset_valid", longint'(o_Valid), 0);
    chk("reset_result", longint'(o_Result), 0);
    chk("reset_pe_planes", longint'({o_PE_Act, o_PE_Weight, o_SignI, o_SignW}), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    fill(8'h01, 8'h01);
    run_job(1, 1, 1'b0, 1'b0, 0);
    fill(8'h03, 8'h03);
    run_job(2, 2, 1'b1, 1'b0, 0);
    fill(8'h80, 8'h80);
    run_job(8, 8, 1'b1, 1'b1, 0);
    fill(8'h80, 8'h7F);
    run_job(8, 8, 1'b1, 1'b1, 0);

    // Backpressure then a back-to-back accept
    fill(8'h01, 8'h01);
    run_job(1, 1, 1'b0, 1'b0, 5);
    fill_rand();
    run_job(3, 2, 1'b1, 1'b1, 0);

    // Reset during the third RUN cycle of a 4x4 job
    fill_rand();
    for (int l = 0; l < LANES; l++) begin
      i_Act[l*MB +: MB]    = act[l];
      i_Weight[l*MB +: MB] = wgt[l];
    end
    i_ActBits = 4'd4; i_WBits = 4'd4; i_ActSigned = 1'b1; i_WSigned = 1'b0;
    i_Valid = 1'b1;
    @(posedge CLK); #1;
    i_Valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_ready", longint'(o_Ready), 1);
    chk("abort_pe_planes", longint'({o_PE_Act, o_PE_Weight, o_SignI, o_SignW}), 0);
    chk("abort_result", longint'(o_Result), 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_Valid !== 1'b0) bad++;
      @(posedge CLK); #1;
    end
    chk("abort_no_valid", bad, 0);
    fill(8'h01, 8'h01);
    run_job(1, 1, 1'b0, 1'b0, 0);

    // Precision clamping
    fill_rand();
    run_job(0, 12, 1'b1, 1'b1, 0);
    fill_rand();
    run_job(15, 0, 1'b0, 1'b1, 1);

    for (int t = 0; t < 40; t++) begin
      fill_rand();
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
